// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the oversampling UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    // Oversample indices: two early samples are stored, the third is taken
    // live and the bit is decided on the last one.
    localparam logic [3:0] OS_SAMPLE_A = 4'd7;
    localparam logic [3:0] OS_SAMPLE_B = 4'd8;
    localparam logic [3:0] OS_SAMPLE_C = 4'd9;
    localparam logic [3:0] OS_LAST     = 4'(OVERSAMPLE - 1);

    // Status bit positions in rd_data, counted upward from bit DATA_W.
    localparam int ST_FERR_OFS = 0;
    localparam int ST_PERR_OFS = 1;
    localparam int ST_BRK_OFS  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus-side read port of the receiver: FIFO drain, status and overrun clear.
interface uart_rx_fifo_if #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              rd_en;
    logic              clr_overrun;
    logic [DATA_W+2:0] rd_data;
    logic              rd_valid;
    logic [LVL_W-1:0]  fifo_level;
    logic              overrun;

    modport master (
        output rd_en, clr_overrun,
        input  rd_data, rd_valid, fifo_level, overrun
    );

    modport slave (
        input  rd_en, clr_overrun,
        output rd_data, rd_valid, fifo_level, overrun
    );
endinterface

// File: rtl/uart_rx_fifo_fifo.sv
// First-word-fall-through FIFO with a registered head so the output is 0
// after reset and holds the last word while empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A full FIFO still accepts a word when the same cycle frees a slot.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Next pointers, level and head word; the head bypasses memory when the
    // word being written is the one that becomes the head.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = wdata;
            else                                   head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointer, level and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign rdata = head_q;
    assign level = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver with majority voting, false-start
// rejection, per-word status and an FWFT receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             rx,
    input  logic [3:0]       bits_per_word,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop_bit,
    output logic             busy,
    uart_rx_fifo_if.slave    bus
);
    localparam int WORD_W = DATA_W + 3;

    logic             rx_meta_q, rxs_q;
    logic [DIV_W-1:0] tick_cnt_q;
    logic             tick;

    rx_state_e        state_q, state_d;
    logic [3:0]       os_cnt_q, os_cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic             samp_a_q, samp_a_d;
    logic             samp_b_q, samp_b_d;
    logic [3:0]       bpw_q, bpw_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             two_stop_q, two_stop_d;
    logic             par_bit_q, par_bit_d;
    logic             par_err_q, par_err_d;
    logic             frame_err_q, frame_err_d;
    logic             brk_q, brk_d;
    logic             overrun_q, overrun_d;

    logic             maj;
    logic             brk_now;
    logic [3:0]       bpw_in;
    logic             push;
    logic [WORD_W-1:0] push_word;
    logic             fifo_full;
    logic             fifo_empty;

    assign tick    = (tick_cnt_q >= clk_div);
    assign maj     = maj3(samp_a_q, samp_b_q, rxs_q);
    assign brk_now = (data_q == '0) && (!par_en_q || !par_bit_q) && !maj;
    assign bpw_in  = (bits_per_word < 4'd5)          ? 4'd5 :
                     (bits_per_word > 4'(DATA_W))   ? 4'(DATA_W) : bits_per_word;

    // Receiver state machine: all frame decisions happen on oversample ticks.
    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        data_d      = data_q;
        samp_a_d    = samp_a_q;
        samp_b_d    = samp_b_q;
        bpw_d       = bpw_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        two_stop_d  = two_stop_q;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        brk_d       = brk_q;
        push        = 1'b0;
        push_word   = {3'b000, data_q};

        if (tick) begin
            if (state_q != IDLE)           os_cnt_d = os_cnt_q + 4'd1;
            if (os_cnt_q == OS_SAMPLE_A)   samp_a_d = rxs_q;
            if (os_cnt_q == OS_SAMPLE_B)   samp_b_d = rxs_q;

            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_d     = START;
                        os_cnt_d    = '0;
                        data_d      = '0;
                        par_bit_d   = 1'b0;
                        par_err_d   = 1'b0;
                        frame_err_d = 1'b0;
                        brk_d       = 1'b0;
                        bpw_d       = bpw_in;
                        par_en_d    = parity_en;
                        par_odd_d   = parity_odd;
                        two_stop_d  = two_stop_bit;
                    end
                end
                START: begin
                    if (os_cnt_q == OS_SAMPLE_C && maj) begin
                        state_d  = IDLE;
                        os_cnt_d = '0;
                    end else if (os_cnt_q == OS_LAST) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    if (os_cnt_q == OS_SAMPLE_C) begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (bit_idx_q == 4'(i)) data_d[i] = maj;
                        end
                    end
                    if (os_cnt_q == OS_LAST) begin
                        if (bit_idx_q == bpw_q - 4'd1) state_d = par_en_q ? PARITY : STOP1;
                        else                           bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
                PARITY: begin
                    if (os_cnt_q == OS_SAMPLE_C) begin
                        par_bit_d = maj;
                        par_err_d = maj ^ (^data_q) ^ par_odd_q;
                    end
                    if (os_cnt_q == OS_LAST) state_d = STOP1;
                end
                STOP1: begin
                    if (os_cnt_q == OS_SAMPLE_C) begin
                        frame_err_d = !maj;
                        brk_d       = brk_now;
                        if (!two_stop_q) begin
                            push                              = 1'b1;
                            push_word[DATA_W + ST_BRK_OFS]    = brk_now;
                            push_word[DATA_W + ST_PERR_OFS]   = par_err_q;
                            push_word[DATA_W + ST_FERR_OFS]   = !maj;
                            state_d                           = IDLE;
                            os_cnt_d                          = '0;
                        end
                    end
                    if (os_cnt_q == OS_LAST && two_stop_q) state_d = STOP2;
                end
                STOP2: begin
                    if (os_cnt_q == OS_SAMPLE_C) begin
                        push                              = 1'b1;
                        push_word[DATA_W + ST_BRK_OFS]    = brk_q;
                        push_word[DATA_W + ST_PERR_OFS]   = par_err_q;
                        push_word[DATA_W + ST_FERR_OFS]   = frame_err_q | !maj;
                        state_d                           = IDLE;
                        os_cnt_d                          = '0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    os_cnt_d = '0;
                end
            endcase
        end
    end

    // Sticky overrun: a fresh drop wins over a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (push && fifo_full && !bus.rd_en) overrun_d = 1'b1;
        else if (bus.clr_overrun)            overrun_d = 1'b0;
    end

    // Synchronizer, tick divider, FSM and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            tick_cnt_q  <= '0;
            state_q     <= IDLE;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            data_q      <= '0;
            samp_a_q    <= 1'b1;
            samp_b_q    <= 1'b1;
            bpw_q       <= 4'd8;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            brk_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            tick_cnt_q  <= tick ? '0 : tick_cnt_q + DIV_W'(1);
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            data_q      <= data_d;
            samp_a_q    <= samp_a_d;
            samp_b_q    <= samp_b_d;
            bpw_q       <= bpw_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            two_stop_q  <= two_stop_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            brk_q       <= brk_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_word),
        .pop   (bus.rd_en),
        .rdata (bus.rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bus.fifo_level)
    );

    assign bus.rd_valid = !fifo_empty;
    assign bus.overrun  = overrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table of single frames plus
// hand sequences for false start, break, overrun, full push+pop and reset.
module tb_uart_rx_fifo;
    localparam int DATA_W     = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] clk_div;
    logic             rx;
    logic [3:0]       bits_per_word;
    logic             parity_en;
    logic             parity_odd;
    logic             two_stop_bit;
    logic             busy;

    uart_rx_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_div       (clk_div),
        .rx            (rx),
        .bits_per_word (bits_per_word),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .two_stop_bit  (two_stop_bit),
        .busy          (busy),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         div;
        logic [3:0] bpw;
        int         nbits;
        logic [8:0] d;
        logic       pe;
        logic       po;
        logic       pbit;
        logic       ts;
        logic       s1;
        logic       s2;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input vec_t v);
        logic [15:0] seq;
        int pos;
        seq    = '1;
        seq[0] = 1'b0;
        pos    = 1;
        for (int i = 0; i < v.nbits; i++) begin
            seq[pos] = v.d[i];
            pos++;
        end
        if (v.pe) begin
            seq[pos] = v.pbit;
            pos++;
        end
        seq[pos] = v.s1;
        pos++;
        if (v.ts) seq[pos] = v.s2;
        return seq;
    endfunction

    function automatic int flen(input vec_t v);
        return 2 + v.nbits + (v.pe ? 1 : 0) + (v.ts ? 1 : 0);
    endfunction

    function automatic logic [15:0] f8n1(input logic [7:0] b);
        return {6'h3F, 1'b1, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [15:0] seq, input int n, input int cyc);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rx = seq[i];
            repeat (cyc) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // Returns at the negedge just before the 8N1 stop-bit decision edge
    // (clk_div = 0): detect on the 3rd edge after the start, then 153 ticks.
    task automatic at_push();
        @(negedge rx);
        repeat (156) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (8) @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 0);
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic set_8n1();
        clk_div       = '0;
        bits_per_word = 4'd8;
        parity_en     = 1'b0;
        parity_odd    = 1'b0;
        two_stop_bit  = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           div bpw  n  data    pe po pb ts s1 s2 expected
        vecs[0]  = '{0, 4'd8,  8, 9'h0A5, 0, 0, 0, 0, 1, 1, 12'h0A5};
        vecs[1]  = '{0, 4'd7,  7, 9'h041, 1, 0, 1, 0, 1, 1, 12'h441};
        vecs[2]  = '{0, 4'd7,  7, 9'h041, 1, 0, 0, 0, 1, 1, 12'h041};
        vecs[3]  = '{0, 4'd8,  8, 9'h03C, 0, 0, 0, 1, 1, 0, 12'h23C};
        vecs[4]  = '{0, 4'd8,  8, 9'h000, 1, 1, 1, 0, 1, 1, 12'h000};
        vecs[5]  = '{1, 4'd9,  9, 9'h1FF, 0, 0, 0, 0, 1, 1, 12'h1FF};
        vecs[6]  = '{0, 4'd3,  5, 9'h015, 0, 0, 0, 0, 1, 1, 12'h015};
        vecs[7]  = '{3, 4'd15, 9, 9'h100, 0, 0, 0, 0, 1, 1, 12'h100};
        vecs[8]  = '{0, 4'd8,  8, 9'h080, 1, 0, 1, 0, 1, 1, 12'h080};
        vecs[9]  = '{0, 4'd8,  8, 9'h080, 1, 1, 1, 0, 1, 1, 12'h480};
        vecs[10] = '{0, 4'd8,  8, 9'h055, 0, 0, 0, 0, 0, 1, 12'h255};
        vecs[11] = '{0, 4'd8,  8, 9'h000, 0, 0, 0, 0, 0, 1, 12'hA00};
        vecs[12] = '{0, 4'd8,  8, 9'h000, 1, 0, 1, 0, 0, 1, 12'h600};

        rst             = 1'b1;
        rx              = 1'b1;
        bus.rd_en       = 1'b0;
        bus.clr_overrun = 1'b0;
        set_8n1();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid",   {31'b0, bus.rd_valid}, 0);
        chk("rst_level",   {29'b0, bus.fifo_level}, 0);
        chk("rst_overrun", {31'b0, bus.overrun}, 0);
        chk("rst_busy",    {31'b0, busy}, 0);
        chk("rst_data",    {20'b0, bus.rd_data}, 0);

        // Table of single frames.
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            clk_div       = DIV_W'(vecs[k].div);
            bits_per_word = vecs[k].bpw;
            parity_en     = vecs[k].pe;
            parity_odd    = vecs[k].po;
            two_stop_bit  = vecs[k].ts;
            send_frame(mk(vecs[k]), flen(vecs[k]), 16 * (vecs[k].div + 1));
            wait_idle();
            chk($sformatf("vec%0d_valid", k), {31'b0, bus.rd_valid}, 1);
            chk($sformatf("vec%0d_data", k),  {20'b0, bus.rd_data}, {20'b0, vecs[k].exp});
            chk($sformatf("vec%0d_level", k), {29'b0, bus.fifo_level}, 1);
            pop_one();
            @(negedge clk);
            chk($sformatf("vec%0d_drain", k), {29'b0, bus.fifo_level}, 0);
        end

        // Push latency: rd_valid rises on the edge after the stop decision.
        set_8n1();
        fork
            send_frame(f8n1(8'hA5), 10, 16);
            begin
                at_push();
                chk("lat_before", {31'b0, bus.rd_valid}, 0);
                @(negedge clk);
                chk("lat_after", {31'b0, bus.rd_valid}, 1);
                chk("lat_data",  {20'b0, bus.rd_data}, 32'h0A5);
            end
        join
        wait_idle();
        pop_one();

        // False start: 3-tick glitch.
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        begin
            int n;
            n = 0;
            while (!busy && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("fs_busy_seen", {31'b0, busy}, 1);
            n = 0;
            while (busy && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("fs_busy_low", {31'b0, busy}, 0);
            chk("fs_short", {31'b0, (n <= 10)}, 1);
        end
        repeat (20) @(negedge clk);
        chk("fs_no_push", {29'b0, bus.fifo_level}, 0);

        // Break: line low for two frame times.
        @(negedge clk);
        rx = 1'b0;
        repeat (320) @(negedge clk);
        rx = 1'b1;
        wait_idle();
        wait_idle();
        chk("brk_valid", {31'b0, bus.rd_valid}, 1);
        chk("brk_data",  {20'b0, bus.rd_data}, 32'hA00);
        pulse_rst();

        // Overrun: five words into four slots.
        for (int b = 1; b <= 5; b++) send_frame(f8n1(8'(b)), 10, 16);
        wait_idle();
        chk("ovr_level", {29'b0, bus.fifo_level}, 4);
        chk("ovr_flag",  {31'b0, bus.overrun}, 1);
        for (int b = 1; b <= 4; b++) begin
            chk($sformatf("ovr_rd%0d", b), {20'b0, bus.rd_data}, b);
            pop_one();
        end
        @(negedge clk);
        chk("ovr_empty", {31'b0, bus.rd_valid}, 0);
        chk("ovr_still", {31'b0, bus.overrun}, 1);
        @(negedge clk);
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.clr_overrun = 1'b0;
        chk("ovr_clr", {31'b0, bus.overrun}, 0);

        // Fill, then a drop coinciding with clr_overrun keeps the flag.
        for (int b = 0; b < 4; b++) send_frame(f8n1(8'h11 + 8'(b)), 10, 16);
        wait_idle();
        chk("full_level", {29'b0, bus.fifo_level}, 4);
        fork
            send_frame(f8n1(8'h20), 10, 16);
            begin
                at_push();
                bus.clr_overrun = 1'b1;
                @(negedge clk);
                bus.clr_overrun = 1'b0;
                chk("clr_vs_set", {31'b0, bus.overrun}, 1);
            end
        join
        wait_idle();
        @(negedge clk);
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.clr_overrun = 1'b0;

        // Push and pop together while full.
        fork
            send_frame(f8n1(8'h15), 10, 16);
            begin
                at_push();
                bus.rd_en = 1'b1;
                @(negedge clk);
                bus.rd_en = 1'b0;
                chk("pp_level",   {29'b0, bus.fifo_level}, 4);
                chk("pp_overrun", {31'b0, bus.overrun}, 0);
                chk("pp_head",    {20'b0, bus.rd_data}, 32'h012);
            end
        join
        wait_idle();
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("pp_rd%0d", b), {20'b0, bus.rd_data}, 32'h012 + b);
            pop_one();
        end
        chk("pp_last", {20'b0, bus.rd_data}, 32'h015);

        // Reset mid-frame with one word still queued.
        fork
            send_frame(f8n1(8'hFF), 10, 16);
            begin
                repeat (80) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("mid_rst_busy",  {31'b0, busy}, 0);
                chk("mid_rst_level", {29'b0, bus.fifo_level}, 0);
                chk("mid_rst_data",  {20'b0, bus.rd_data}, 0);
            end
        join
        repeat (100) @(negedge clk);
        chk("mid_rst_nopush", {29'b0, bus.fifo_level}, 0);
        chk("mid_rst_idle",   {31'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
